// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: serialises a held mono sample onto both slots of a free-running I2S frame.
module audio_i2s_tx #(
  parameter int BCLK_HALF = 18,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample_in,
  input  logic        sample_in_valid,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun,
  output logic        overrun
);
  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [5:0] LAST_BIT = 6'(2 * SLOT_BITS - 1);
  logic [CW-1:0] bclk_cnt_q, bclk_cnt_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] hold_q, hold_d, frame_word_q, frame_word_d;
  logic pending_q, pending_d, armed_q, armed_d;
  logic bclk_q, lrclk_q, sdata_q, frame_start_q, underrun_q, overrun_q;
  logic term, tick, load, bypass, intake, sdata_d;
  logic [4:0] slot_pos;
  logic [3:0] bit_idx;
  always_comb begin
    term = bclk_cnt_q == CW'(BCLK_HALF - 1);
    tick = term && bclk_q;
    bclk_cnt_d = term ? '0 : bclk_cnt_q + 1'b1;
    bit_cnt_d = !tick ? bit_cnt_q : (bit_cnt_q == LAST_BIT) ? 6'd0 : bit_cnt_q + 6'd1;
    load = tick && (bit_cnt_d == 6'd0);
    bypass = load && !pending_q && sample_in_valid;
    intake = sample_in_valid && !bypass;
    frame_word_d = !load ? frame_word_q : bypass ? sample_in : hold_q;
    hold_d = intake ? sample_in : hold_q;
    pending_d = intake || (pending_q && !load);
    armed_d = armed_q || intake;
    slot_pos = bit_cnt_d[4:0];
    bit_idx = 4'(5'd16 - slot_pos);
    sdata_d = (slot_pos != 5'd0) && (slot_pos <= 5'd16) && frame_word_d[bit_idx];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_cnt_q    <= '0;
      bit_cnt_q     <= LAST_BIT;
      hold_q        <= '0;
      frame_word_q  <= '0;
      pending_q     <= 1'b0;
      armed_q       <= 1'b0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      bclk_cnt_q    <= bclk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_q        <= hold_d;
      frame_word_q  <= frame_word_d;
      pending_q     <= pending_d;
      armed_q       <= armed_d;
      bclk_q        <= term ? ~bclk_q : bclk_q;
      lrclk_q       <= tick ? bit_cnt_d[5] : lrclk_q;
      sdata_q       <= tick ? sdata_d : sdata_q;
      frame_start_q <= load;
      // a held sample taken by this frame load is consumed, not dropped
      underrun_q    <= load && !pending_q && !sample_in_valid && armed_q;
      overrun_q     <= intake && pending_q && !load;
    end
  end
  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed checks of framing, hold/bypass, status pulses and async reset.
module tb_audio_i2s_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] sin_a = '0, sin_b = '0;
  logic sv_a = 1'b0, sv_b = 1'b0;
  logic bclk_a, lr_a, sd_a, fs_a, ur_a, or_a;
  logic bclk_b, lr_b, sd_b, fs_b, ur_b, or_b;
  int n_chk = 0, n_pass = 0;
  int ur_cnt_a = 0, or_cnt_a = 0, or_cnt_b = 0;
  localparam logic [63:0] EXP_LR = {32'hFFFF_FFFF, 32'h0000_0000};

  audio_i2s_tx #(.BCLK_HALF(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .sample_in(sin_a), .sample_in_valid(sv_a),
    .i2s_bclk(bclk_a), .i2s_lrclk(lr_a), .i2s_sdata(sd_a),
    .frame_start(fs_a), .underrun(ur_a), .overrun(or_a)
  );
  audio_i2s_tx #(.BCLK_HALF(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_in(sin_b), .sample_in_valid(sv_b),
    .i2s_bclk(bclk_b), .i2s_lrclk(lr_b), .i2s_sdata(sd_b),
    .frame_start(fs_b), .underrun(ur_b), .overrun(or_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ur_cnt_a <= ur_cnt_a + int'(ur_a);
    or_cnt_a <= or_cnt_a + int'(or_a);
    or_cnt_b <= or_cnt_b + int'(or_b);
  end

  function automatic logic [63:0] exp_sd(input logic [15:0] w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      int p;
      p = k % 32;
      if (p >= 1 && p <= 16) r[k] = w[16-p];
    end
    return r;
  endfunction

  function automatic logic [15:0] sval(input int m);
    return 16'h8AA1 + 16'(m) * 16'h0357;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; sv_a = 1'b0; sv_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fs(input bit b, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = ((b ? fs_b : fs_a) === 1'b1);
    end
  endtask

  task automatic capture(input bit b, output logic [63:0] sd, output logic [63:0] lr);
    for (int k = 0; k < 64; k++) begin
      sd[k] = b ? sd_b : sd_a;
      lr[k] = b ? lr_b : lr_a;
      repeat (b ? 36 : 4) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [63:0] sd, lr;
    int u0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({bclk_a, lr_a, sd_a, fs_a, ur_a, or_a, bclk_b, lr_b, sd_b, fs_b, ur_b, or_b} !== 12'h0) $display("FAIL reset_outputs: got %b want 0", {bclk_a, lr_a, sd_a, fs_a, ur_a, or_a, bclk_b, lr_b, sd_b, fs_b, ur_b, or_b}); else n_pass++;
    rst_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      logic [1:0] e;
      @(negedge clk);
      e = {((n / 2) % 2) == 1, n == 4};
      n_chk++; if ({bclk_a, fs_a} !== e) $display("FAIL idle_bclk_fs clk %0d: got %b want %b", n, {bclk_a, fs_a}, e); else n_pass++;
    end
    u0 = ur_cnt_a;
    capture(1'b0, sd, lr);
    n_chk++; if (sd !== 64'h0) $display("FAIL idle_sdata: got %h want 0", sd); else n_pass++;
    n_chk++; if (lr !== EXP_LR) $display("FAIL idle_lrclk: got %h want %h", lr, EXP_LR); else n_pass++;
    n_chk++; if (fs_a !== 1'b1) $display("FAIL idle_frame_period: got %b want 1", fs_a); else n_pass++;
    n_chk++; if ({ur_cnt_a - u0, ur_a} !== {32'd0, 1'b0}) $display("FAIL idle_no_underrun: got %0d/%b want 0/0", ur_cnt_a - u0, ur_a); else n_pass++;
  endtask

  task automatic test_single;
    logic [63:0] sd, lr;
    bit ok;
    do_reset();
    @(negedge clk); sv_a = 1'b1; sin_a = 16'hA5C3;
    @(negedge clk); sv_a = 1'b0;
    wait_fs(1'b0, 20, ok);
    n_chk++; if (!ok) $display("FAIL single_fs_timeout: got none want frame_start"); else n_pass++;
    n_chk++; if ({ur_a, or_a} !== 2'b00) $display("FAIL single_status: got %b want 00", {ur_a, or_a}); else n_pass++;
    capture(1'b0, sd, lr);
    n_chk++; if (sd !== exp_sd(16'hA5C3)) $display("FAIL single_sdata: got %h want %h", sd, exp_sd(16'hA5C3)); else n_pass++;
    n_chk++; if (lr !== EXP_LR) $display("FAIL single_lrclk: got %h want %h", lr, EXP_LR); else n_pass++;
  endtask

  task automatic test_underrun;
    logic [63:0] sd, lr;
    bit ok;
    int u0;
    n_chk++; if (ur_a !== 1'b1) $display("FAIL repeat_a5c3_underrun: got %b want 1", ur_a); else n_pass++;
    @(negedge clk); sv_a = 1'b1; sin_a = 16'h8001;
    @(negedge clk); sv_a = 1'b0;
    wait_fs(1'b0, 300, ok);
    n_chk++; if (!ok) $display("FAIL underrun_fs_timeout: got none want frame_start"); else n_pass++;
    n_chk++; if (ur_a !== 1'b0) $display("FAIL load_8001_underrun: got %b want 0", ur_a); else n_pass++;
    capture(1'b0, sd, lr);
    n_chk++; if (sd !== exp_sd(16'h8001)) $display("FAIL frame_8001: got %h want %h", sd, exp_sd(16'h8001)); else n_pass++;
    u0 = ur_cnt_a;
    n_chk++; if (ur_a !== 1'b1) $display("FAIL repeat_8001_underrun: got %b want 1", ur_a); else n_pass++;
    capture(1'b0, sd, lr);
    n_chk++; if (sd !== exp_sd(16'h8001)) $display("FAIL repeat_8001: got %h want %h", sd, exp_sd(16'h8001)); else n_pass++;
    n_chk++; if (ur_cnt_a - u0 !== 1) $display("FAIL underrun_once_per_frame: got %0d want 1", ur_cnt_a - u0); else n_pass++;
    n_chk++; if (ur_a !== 1'b1) $display("FAIL repeat2_underrun: got %b want 1", ur_a); else n_pass++;
  endtask

  task automatic test_overrun;
    logic [63:0] sd, lr;
    bit ok;
    int o0;
    o0 = or_cnt_a;
    @(negedge clk); sv_a = 1'b1; sin_a = 16'h1111;
    @(negedge clk); sv_a = 1'b0;
    n_chk++; if (or_a !== 1'b0) $display("FAIL overrun_first: got %b want 0", or_a); else n_pass++;
    repeat (5) @(negedge clk);
    sv_a = 1'b1; sin_a = 16'h2222;
    @(negedge clk); sv_a = 1'b0;
    n_chk++; if (or_a !== 1'b1) $display("FAIL overrun_second: got %b want 1", or_a); else n_pass++;
    @(negedge clk);
    n_chk++; if (or_a !== 1'b0) $display("FAIL overrun_width: got %b want 0", or_a); else n_pass++;
    wait_fs(1'b0, 300, ok);
    n_chk++; if (!ok) $display("FAIL overrun_fs_timeout: got none want frame_start"); else n_pass++;
    n_chk++; if (or_cnt_a - o0 !== 1) $display("FAIL overrun_count: got %0d want 1", or_cnt_a - o0); else n_pass++;
    n_chk++; if (ur_a !== 1'b0) $display("FAIL overrun_load_underrun: got %b want 0", ur_a); else n_pass++;
    capture(1'b0, sd, lr);
    n_chk++; if (sd !== exp_sd(16'h2222)) $display("FAIL overrun_newest_wins: got %h want %h", sd, exp_sd(16'h2222)); else n_pass++;
  endtask

  task automatic test_bypass;
    logic [63:0] sd, lr;
    repeat (255) @(negedge clk);
    sv_a = 1'b1; sin_a = 16'h7FFF;
    @(negedge clk);
    n_chk++; if (fs_a !== 1'b1) $display("FAIL bypass_fs: got %b want 1", fs_a); else n_pass++;
    n_chk++; if ({ur_a, or_a} !== 2'b00) $display("FAIL bypass_status: got %b want 00", {ur_a, or_a}); else n_pass++;
    sv_a = 1'b0;
    capture(1'b0, sd, lr);
    n_chk++; if (sd !== exp_sd(16'h7FFF)) $display("FAIL bypass_sdata: got %h want %h", sd, exp_sd(16'h7FFF)); else n_pass++;
    n_chk++; if ({fs_a, ur_a} !== 2'b11) $display("FAIL bypass_pending_clear: got %b want 11", {fs_a, ur_a}); else n_pass++;
  endtask

  task automatic test_stream;
    bit ok;
    int o0;
    do_reset();
    wait_fs(1'b1, 100, ok);
    n_chk++; if (!ok) $display("FAIL stream_fs_timeout: got none want frame_start"); else n_pass++;
    o0 = or_cnt_b;
    fork
      begin
        repeat (10) @(negedge clk);
        for (int m = 0; m < 10; m++) begin
          sv_b = 1'b1; sin_b = sval(m);
          @(negedge clk); sv_b = 1'b0;
          n_chk++; if (or_b !== (m == 1)) $display("FAIL stream_overrun_%0d: got %b want %b", m, or_b, m == 1); else n_pass++;
          repeat (2271) @(negedge clk);
        end
      end
      begin
        logic [63:0] sd, lr;
        bit ok2;
        wait_fs(1'b1, 3000, ok2);
        n_chk++; if (!ok2) $display("FAIL stream_load_timeout: got none want frame_start"); else n_pass++;
        for (int m = 1; m < 10; m++) begin
          n_chk++; if (ur_b !== 1'b0) $display("FAIL stream_underrun_%0d: got %b want 0", m, ur_b); else n_pass++;
          capture(1'b1, sd, lr);
          n_chk++; if (sd !== exp_sd(sval(m))) $display("FAIL stream_frame_%0d: got %h want %h", m, sd, exp_sd(sval(m))); else n_pass++;
        end
      end
    join
    n_chk++; if (or_cnt_b - o0 !== 1) $display("FAIL stream_overrun_count: got %0d want 1", or_cnt_b - o0); else n_pass++;
    repeat (33 * 36 + 20) @(negedge clk);
    n_chk++; if ({bclk_b, lr_b, sd_b} !== 3'b111) $display("FAIL midslot_active: got %b want 111", {bclk_b, lr_b, sd_b}); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({bclk_b, lr_b, sd_b, fs_b, ur_b, or_b} !== 6'h0) $display("FAIL async_reset_b: got %b want 0", {bclk_b, lr_b, sd_b, fs_b, ur_b, or_b}); else n_pass++;
    n_chk++; if ({bclk_a, lr_a, sd_a, fs_a, ur_a, or_a} !== 6'h0) $display("FAIL async_reset_a: got %b want 0", {bclk_a, lr_a, sd_a, fs_a, ur_a, or_a}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_underrun();
    test_overrun();
    test_bypass();
    test_stream();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
